// File: rtl/tgate_phase_sequencer_if.sv
// Control/status bundle between the digital sequencer and its requester.
// Carries the transfer handshake plus the pass-gate phase controls.
interface tgate_phase_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             abort;
    logic             sdata;
    logic             phi1;
    logic             phi1_n;
    logic             phi2;
    logic             phi2_n;
    logic             busy;
    logic             done;
    logic [3:0]       bitcnt;

    modport master (
        output start, din, abort,
        input  sdata, phi1, phi1_n, phi2, phi2_n,
        input  busy, done, bitcnt
    );

    modport slave (
        input  start, din, abort,
        output sdata, phi1, phi1_n, phi2, phi2_n,
        output busy, done, bitcnt
    );
endinterface

// File: rtl/tgate_phase_sequencer.sv
// Serializes a word LSB first onto a transmission-gate shift chain,
// driving two non-overlapping complementary gate phases per bit.
module tgate_phase_sequencer #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 4,
    parameter int DEAD  = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    tgate_phase_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, P1, D1, P2, D2} state_t;

    localparam logic [15:0] HLD = 16'(HOLD - 1);
    localparam logic [15:0] DED = 16'(DEAD - 1);
    localparam logic [3:0]  LAST = 4'(WIDTH - 1);

    state_t           state;
    logic [15:0]      cnt;
    logic [WIDTH-1:0] shadow;

    // Every gate output is a flop; phase counter reloads on each state change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shadow     <= '0;
            bus.phi1   <= 1'b0;
            bus.phi1_n <= 1'b1;
            bus.phi2   <= 1'b0;
            bus.phi2_n <= 1'b1;
            bus.sdata  <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.bitcnt <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state      <= IDLE;
                cnt        <= '0;
                bus.phi1   <= 1'b0;
                bus.phi1_n <= 1'b1;
                bus.phi2   <= 1'b0;
                bus.phi2_n <= 1'b1;
                bus.sdata  <= 1'b0;
                bus.busy   <= 1'b0;
                bus.bitcnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            state      <= P1;
                            cnt        <= HLD;
                            shadow     <= bus.din;
                            bus.sdata  <= bus.din[0];
                            bus.bitcnt <= '0;
                            bus.busy   <= 1'b1;
                            bus.phi1   <= 1'b1;
                            bus.phi1_n <= 1'b0;
                        end
                    end
                    P1: begin
                        if (cnt == '0) begin
                            state      <= D1;
                            cnt        <= DED;
                            bus.phi1   <= 1'b0;
                            bus.phi1_n <= 1'b1;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    D1: begin
                        if (cnt == '0) begin
                            state      <= P2;
                            cnt        <= HLD;
                            bus.phi2   <= 1'b1;
                            bus.phi2_n <= 1'b0;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    P2: begin
                        if (cnt == '0) begin
                            state      <= D2;
                            cnt        <= DED;
                            bus.phi2   <= 1'b0;
                            bus.phi2_n <= 1'b1;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                    D2: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 16'd1;
                        end else if (bus.bitcnt != LAST) begin
                            state      <= P1;
                            cnt        <= HLD;
                            shadow     <= shadow >> 1;
                            bus.sdata  <= shadow[1];
                            bus.bitcnt <= bus.bitcnt + 4'd1;
                            bus.phi1   <= 1'b1;
                            bus.phi1_n <= 1'b0;
                        end else begin
                            state      <= IDLE;
                            cnt        <= '0;
                            bus.sdata  <= 1'b0;
                            bus.bitcnt <= '0;
                            bus.busy   <= 1'b0;
                            bus.done   <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tgate_phase_sequencer.sv
// Directed bench for tgate_phase_sequencer (WIDTH=8, HOLD=4, DEAD=2).
// Sample index k is the value seen between edge k-1 and edge k.
module tb_tgate_phase_sequencer;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    bit   chk_en;
    int   off_run;
    int   last_ph;

    logic       h_busy [0:255];
    logic       h_done [0:255];
    logic       h_p1   [0:255];
    logic       h_p2   [0:255];
    logic       h_sd   [0:255];
    logic [3:0] h_bc   [0:255];

    tgate_phase_sequencer_if #(.WIDTH(8)) bus ();

    tgate_phase_sequencer #(.WIDTH(8), .HOLD(4), .DEAD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst_n) begin
            off_run = 0;
            last_ph = 0;
        end else if (chk_en) begin
            tests++;
            if (bus.phi1_n !== ~bus.phi1 || bus.phi2_n !== ~bus.phi2) begin
                fails++;
                $display("FAIL complement: phi1=%b phi1_n=%b phi2=%b phi2_n=%b",
                         bus.phi1, bus.phi1_n, bus.phi2, bus.phi2_n);
            end
            tests++;
            if ((bus.phi1 & bus.phi2) !== 1'b0) begin
                fails++;
                $display("FAIL overlap: phi1&phi2=%b want 0", bus.phi1 & bus.phi2);
            end
            if (bus.phi1 || bus.phi2) begin
                if ((bus.phi1 && last_ph == 2) || (bus.phi2 && last_ph == 1)) begin
                    tests++;
                    if (off_run < 2) begin
                        fails++;
                        $display("FAIL deadtime: got %0d off cycles want >=2", off_run);
                    end
                end
                last_ph = bus.phi1 ? 1 : 2;
                off_run = 0;
            end else begin
                off_run++;
            end
        end
    end

    task automatic run(input int n, input int inj_at, input logic inj_start,
                       input logic [7:0] inj_din, input logic inj_abort,
                       input logic hold);
        @(posedge clk);
        #1;
        for (int k = 1; k <= n; k++) begin
            bus.start = hold;
            bus.abort = 1'b0;
            if (k == inj_at) begin
                bus.start = inj_start;
                bus.din   = inj_din;
                bus.abort = inj_abort;
            end
            @(negedge clk);
            h_busy[k] = bus.busy;
            h_done[k] = bus.done;
            h_p1[k]   = bus.phi1;
            h_p2[k]   = bus.phi2;
            h_sd[k]   = bus.sdata;
            h_bc[k]   = bus.bitcnt;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.din   = 8'hA5;
        bus.abort = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.phi1, bus.phi1_n, bus.phi2, bus.phi2_n, bus.busy,
                 bus.done, bus.sdata, bus.bitcnt} !== 11'b0101_000_0000) begin
                fails++;
                $display("FAIL reset_outputs: got p1=%b p1n=%b p2=%b p2n=%b b=%b d=%b s=%b c=%0d",
                         bus.phi1, bus.phi1_n, bus.phi2, bus.phi2_n, bus.busy,
                         bus.done, bus.sdata, bus.bitcnt);
            end
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0 || bus.phi1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_start: busy=%b phi1=%b want 0 0", bus.busy, bus.phi1);
        end
        chk_en = 1'b1;
    endtask

    task automatic test_single;
        logic [7:0] d;
        logic [7:0] ser;
        int b;
        int ph;
        logic eb;
        d         = 8'hA5;
        ser       = '0;
        bus.din   = d;
        bus.start = 1'b1;
        run(97, 30, 1'b1, 8'hFF, 1'b0, 1'b0);
        for (int k = 1; k <= 97; k++) begin
            b  = (k - 1) / 12;
            ph = (k - 1) % 12;
            eb = (k <= 96);
            tests++;
            if (h_busy[k] !== eb || h_done[k] !== (k == 97)) begin
                fails++;
                $display("FAIL single_busy_done k=%0d: busy=%b done=%b want %b %b",
                         k, h_busy[k], h_done[k], eb, k == 97);
            end
            tests++;
            if (h_p1[k] !== (eb && ph < 4) || h_p2[k] !== (eb && ph >= 6 && ph < 10)) begin
                fails++;
                $display("FAIL single_phase k=%0d: phi1=%b phi2=%b want %b %b",
                         k, h_p1[k], h_p2[k], eb && ph < 4, eb && ph >= 6 && ph < 10);
            end
            if (eb) begin
                tests++;
                if (h_bc[k] !== 4'(b) || h_sd[k] !== d[b]) begin
                    fails++;
                    $display("FAIL single_bit k=%0d: bitcnt=%0d sdata=%b want %0d %b",
                             k, h_bc[k], h_sd[k], b, d[b]);
                end
                if (ph == 0) ser[b] = h_sd[k];
            end
        end
        tests++;
        if (ser !== 8'hA5) begin
            fails++;
            $display("FAIL single_serial: got %h want a5", ser);
        end
    endtask

    task automatic test_abort;
        logic [7:0] ser;
        int hits;
        bus.din   = 8'hA5;
        bus.start = 1'b1;
        run(45, 40, 1'b0, 8'h00, 1'b1, 1'b0);
        tests++;
        if (h_busy[40] !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre: busy=%b want 1", h_busy[40]);
        end
        tests++;
        if ({h_p1[41], h_p2[41], h_busy[41], h_sd[41], h_bc[41]} !== 8'b0) begin
            fails++;
            $display("FAIL abort_state: p1=%b p2=%b busy=%b sdata=%b bitcnt=%0d want all 0",
                     h_p1[41], h_p2[41], h_busy[41], h_sd[41], h_bc[41]);
        end
        hits = 0;
        for (int k = 1; k <= 45; k++) if (h_done[k] !== 1'b0) hits++;
        tests++;
        if (hits != 0) begin
            fails++;
            $display("FAIL abort_done: %0d done cycles want 0", hits);
        end
        ser       = '0;
        bus.din   = 8'h3C;
        bus.start = 1'b1;
        run(97, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) ser[b] = h_sd[b * 12 + 1];
        tests++;
        if (h_busy[1] !== 1'b1 || h_busy[96] !== 1'b1 || h_done[97] !== 1'b1 || ser !== 8'h3C) begin
            fails++;
            $display("FAIL abort_restart: busy1=%b busy96=%b done97=%b ser=%h want 1 1 1 3c",
                     h_busy[1], h_busy[96], h_done[97], ser);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic [7:0] s1;
        logic [7:0] s2;
        int kk;
        int ph;
        logic eb;
        d         = 8'h3C;
        s1        = '0;
        s2        = '0;
        bus.din   = d;
        bus.start = 1'b1;
        run(194, 0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 194; k++) begin
            kk = (k > 97) ? k - 97 : k;
            ph = (kk - 1) % 12;
            eb = (kk <= 96);
            tests++;
            if (h_busy[k] !== eb || h_done[k] !== (kk == 97) ||
                h_p1[k] !== (eb && ph < 4)) begin
                fails++;
                $display("FAIL b2b k=%0d: busy=%b done=%b phi1=%b want %b %b %b",
                         k, h_busy[k], h_done[k], h_p1[k], eb, kk == 97, eb && ph < 4);
            end
        end
        for (int b = 0; b < 8; b++) begin
            s1[b] = h_sd[b * 12 + 1];
            s2[b] = h_sd[b * 12 + 98];
        end
        tests++;
        if (s1 !== d || s2 !== d) begin
            fails++;
            $display("FAIL b2b_serial: got %h %h want 3c 3c", s1, s2);
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_cleanup: busy=%b want 0", bus.busy);
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        chk_en = 1'b0;
        test_reset;
        test_single;
        test_abort;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
